// File: rtl/fft_host_ctrl.sv
// fft_host_ctrl: host-side load/start/drain sequencer for the 4-bank radix-4 FFT core.
// Optional FFT_HOST_DIGIT_REV_EN: drain in base-4 digit-reversed storage order (natural frequency order out).
`default_nettype none

module fft_host_ctrl #(
   parameter int D_BIT = 17,
   parameter int A_BIT = 8
) (
   input  logic                 iCLK,
   input  logic                 iRESET,
   input  logic                 iGO,
   input  logic [D_BIT-2:0]     iS_DATA,
   input  logic                 iS_VALID,
   output logic                 oS_READY,
   output logic [D_BIT-2:0]     oFFT_DATA,
   output logic [A_BIT-1:0]     oFFT_ADDR_WR,
   output logic [3:0]           oFFT_WE,
   output logic [A_BIT-1:0]     oFFT_ADDR_RD,
   input  logic [D_BIT-1:0]     iFFT_RE_0,
   input  logic [D_BIT-1:0]     iFFT_RE_1,
   input  logic [D_BIT-1:0]     iFFT_RE_2,
   input  logic [D_BIT-1:0]     iFFT_RE_3,
   output logic                 oFFT_START,
   input  logic                 iFFT_RDY,
   output logic [D_BIT-1:0]     oM_DATA,
   output logic [A_BIT+1:0]     oM_INDEX,
   output logic                 oM_VALID,
   input  logic                 iM_READY,
   output logic                 oM_LAST,
   output logic                 oBUSY,
   output logic                 oDONE
);
   localparam int IW = A_BIT + 2;
   localparam logic [IW-1:0] LAST_IDX = '1;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_KICK, S_WAIT, S_READ} state_t;

`ifdef FFT_HOST_DIGIT_REV_EN
   generate
      if (IW % 2 != 0) begin : g_bad_parity
         $error("fft_host_ctrl: digit reversal needs A_BIT+2 even");
      end
   endgenerate
`endif

   function automatic logic [IW-1:0] storage_idx(input logic [IW-1:0] k);
`ifdef FFT_HOST_DIGIT_REV_EN
      logic [IW-1:0] r;
      r = '0;
      for (int i = 0; i < IW / 2; i++) r[2*i +: 2] = k[IW-2-2*i +: 2];
      return r;
`else
      return k;
`endif
   endfunction

   state_t              state_q, state_d;
   logic [IW-1:0]       ld_idx_q, ld_idx_d;
   logic                wait_arm_q, wait_arm_d;
   logic [IW:0]         iss_cnt_q, iss_cnt_d;
   logic                rd_pend_q, rd_pend_d;
   logic [1:0]          rd_sel_q, rd_sel_d;
   logic [1:0]          fifo_cnt_q, fifo_cnt_d;
   logic                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [D_BIT-1:0]    fifo_q [2];
   logic [D_BIT-1:0]    fifo_d [2];
   logic [IW-1:0]       out_idx_q, out_idx_d;
   logic                done_q, done_d;

   logic                load_hs, pop, issue;
   logic [2:0]          occ;
   logic [IW-1:0]       s_iss;
   logic [D_BIT-1:0]    rd_data;

   assign load_hs = iS_VALID && (state_q == S_LOAD);
   assign pop     = (fifo_cnt_q != 2'd0) && iM_READY;
   assign occ     = {1'b0, fifo_cnt_q} + {2'b00, rd_pend_q};
   // A word popped this cycle frees its slot, which keeps the drain at one word per cycle.
   assign issue   = (state_q == S_READ) && !iss_cnt_q[IW] &&
                    ((occ < 3'd2) || (pop && (occ == 3'd2)));
   assign s_iss   = storage_idx(iss_cnt_q[IW-1:0]);

   always_comb begin
      case (rd_sel_q)
         2'd0:    rd_data = iFFT_RE_0;
         2'd1:    rd_data = iFFT_RE_1;
         2'd2:    rd_data = iFFT_RE_2;
         default: rd_data = iFFT_RE_3;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      ld_idx_d   = ld_idx_q;
      wait_arm_d = wait_arm_q;
      iss_cnt_d  = iss_cnt_q;
      rd_pend_d  = issue;
      rd_sel_d   = rd_sel_q;
      fifo_cnt_d = fifo_cnt_q + {1'b0, rd_pend_q} - {1'b0, pop};
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      fifo_d     = fifo_q;
      out_idx_d  = out_idx_q;
      done_d     = 1'b0;

      if (issue) begin
         rd_sel_d  = s_iss[IW-1:A_BIT];
         iss_cnt_d = iss_cnt_q + 1'b1;
      end
      if (rd_pend_q) begin
         fifo_d[wr_ptr_q] = rd_data;
         wr_ptr_d         = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d  = ~rd_ptr_q;
         out_idx_d = out_idx_q + 1'b1;
      end

      case (state_q)
         S_IDLE: if (iGO) begin
            state_d  = S_LOAD;
            ld_idx_d = '0;
         end
         S_LOAD: if (load_hs) begin
            ld_idx_d = ld_idx_q + 1'b1;
            if (ld_idx_q == LAST_IDX) state_d = S_KICK;
         end
         S_KICK: begin
            state_d    = S_WAIT;
            wait_arm_d = 1'b0;
         end
         S_WAIT: begin
            // A ready level left over from the previous frame is ignored in the first WAIT cycle.
            wait_arm_d = 1'b1;
            if (wait_arm_q && iFFT_RDY) begin
               state_d   = S_READ;
               iss_cnt_d = '0;
               out_idx_d = '0;
               wr_ptr_d  = 1'b0;
               rd_ptr_d  = 1'b0;
            end
         end
         S_READ: if (pop && (out_idx_q == LAST_IDX)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge iCLK or posedge iRESET) begin
      if (iRESET) begin
         state_q    <= S_IDLE;
         ld_idx_q   <= '0;
         wait_arm_q <= 1'b0;
         iss_cnt_q  <= '0;
         rd_pend_q  <= 1'b0;
         rd_sel_q   <= '0;
         fifo_cnt_q <= '0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         fifo_q[0]  <= '0;
         fifo_q[1]  <= '0;
         out_idx_q  <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         ld_idx_q   <= ld_idx_d;
         wait_arm_q <= wait_arm_d;
         iss_cnt_q  <= iss_cnt_d;
         rd_pend_q  <= rd_pend_d;
         rd_sel_q   <= rd_sel_d;
         fifo_cnt_q <= fifo_cnt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         fifo_q     <= fifo_d;
         out_idx_q  <= out_idx_d;
         done_q     <= done_d;
      end
   end

   assign oS_READY     = (state_q == S_LOAD);
   assign oFFT_WE      = load_hs ? (4'b0001 << ld_idx_q[IW-1:A_BIT]) : 4'b0000;
   assign oFFT_ADDR_WR = load_hs ? ld_idx_q[A_BIT-1:0] : '0;
   assign oFFT_DATA    = load_hs ? iS_DATA : '0;
   assign oFFT_ADDR_RD = s_iss[A_BIT-1:0];
   assign oFFT_START   = (state_q == S_KICK);
   assign oM_VALID     = (fifo_cnt_q != 2'd0);
   assign oM_DATA      = oM_VALID ? fifo_q[rd_ptr_q] : '0;
   assign oM_INDEX     = oM_VALID ? out_idx_q : '0;
   assign oM_LAST      = oM_VALID && (out_idx_q == LAST_IDX);
   assign oBUSY        = (state_q != S_IDLE);
   assign oDONE        = done_q;

endmodule

`default_nettype wire
